// File: rtl/rc4_encryptor.sv
// RC4 encryptor: S init, KSA and one PRGA step per plaintext byte against an external 256x8 S RAM.
// Define RC4_DROP_EN to discard the first DROP_N keystream bytes (RC4-dropN) before accepting plaintext.
module rc4_encryptor #(
  parameter int MSG_LEN   = 32,
  parameter int KEY_BYTES = 3,
  parameter int DROP_N    = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             pt_data,
  input  logic                   pt_valid,
  output logic                   pt_ready,
  output logic [7:0]             ct_data,
  output logic                   ct_valid,
  output logic [7:0]             ct_index,
  output logic [7:0]             s_address,
  output logic [7:0]             s_data,
  output logic                   s_wren,
  input  logic [7:0]             s_q,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [3:0] {
    IDLE, INIT, RD_I, CAP_I, RD_J, WR_I, WR_J, RD_F, CAP_F, PT_WAIT, DONE
  } state_t;
  typedef enum logic [1:0] {PH_KSA, PH_DROP, PH_PRGA} phase_t;

  state_t                 state_q;
  phase_t                 phase_q;
  logic [7:0]             i_q, j_q, cnt_q;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             addr_q, wdata_q;
  logic                   wren_q, pass_q;
  logic [7:0]             ct_data_q, ct_index_q;
  logic                   ct_valid_q;
  logic [7:0]             si_q, sj_q, pt_q;
  logic [7:0]             j_d, i_inc_d;
`ifdef RC4_DROP_EN
  logic [15:0]            drop_q;
`endif

  // Key byte 0 is the most significant byte of the key.
  function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key, input logic [7:0] idx);
    int                     k;
    logic [8*KEY_BYTES-1:0] sh;
    k  = int'(idx) % KEY_BYTES;
    sh = key >> (8 * (KEY_BYTES - 1 - k));
    return sh[7:0];
  endfunction

  always_comb begin
    i_inc_d = i_q + 8'd1;
    j_d     = j_q + s_q;
    if (phase_q == PH_KSA) j_d = j_d + key_byte(key_q, i_q);
  end

  // Each swap step: RD_I, CAP_I (si arrives, new j), RD_J, WR_I (sj arrives and is written straight back), WR_J.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phase_q    <= PH_KSA;
      i_q        <= '0;
      j_q        <= '0;
      cnt_q      <= '0;
      key_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wren_q     <= 1'b0;
      pass_q     <= 1'b0;
      ct_data_q  <= '0;
      ct_index_q <= '0;
      ct_valid_q <= 1'b0;
`ifdef RC4_DROP_EN
      drop_q     <= '0;
`endif
    end else begin
      wren_q     <= 1'b0;
      pass_q     <= 1'b0;
      ct_valid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            key_q   <= secret_key;
            i_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            phase_q <= PH_KSA;
            addr_q  <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b1;
            state_q <= INIT;
          end
        end
        INIT: begin
          if (i_q == 8'hFF) begin
            i_q     <= '0;
            addr_q  <= '0;
            state_q <= RD_I;
          end else begin
            i_q     <= i_inc_d;
            addr_q  <= i_inc_d;
            wdata_q <= i_inc_d;
            wren_q  <= 1'b1;
          end
        end
        RD_I:  state_q <= CAP_I;
        CAP_I: begin
          j_q     <= j_d;
          addr_q  <= j_d;
          state_q <= RD_J;
        end
        RD_J: begin
          addr_q  <= i_q;
          wren_q  <= 1'b1;
          pass_q  <= 1'b1;
          state_q <= WR_I;
        end
        WR_I: begin
          addr_q  <= j_q;
          wdata_q <= si_q;
          wren_q  <= 1'b1;
          state_q <= WR_J;
        end
        WR_J: begin
          if (phase_q == PH_PRGA) begin
            addr_q  <= si_q + sj_q;
            state_q <= RD_F;
          end
`ifdef RC4_DROP_EN
          else if (phase_q == PH_DROP) begin
            if (drop_q == 16'(DROP_N - 1)) begin
              state_q <= PT_WAIT;
            end else begin
              drop_q  <= drop_q + 16'd1;
              i_q     <= i_inc_d;
              addr_q  <= i_inc_d;
              state_q <= RD_I;
            end
          end
`endif
          else if (i_q != 8'hFF) begin
            i_q     <= i_inc_d;
            addr_q  <= i_inc_d;
            state_q <= RD_I;
          end else begin
            j_q <= '0;
`ifdef RC4_DROP_EN
            // First drop step already carries the PRGA pre-increment of i.
            i_q     <= 8'd1;
            addr_q  <= 8'd1;
            drop_q  <= '0;
            phase_q <= PH_DROP;
            state_q <= RD_I;
`else
            i_q     <= '0;
            state_q <= PT_WAIT;
`endif
          end
        end
        RD_F:  state_q <= CAP_F;
        CAP_F: begin
          ct_data_q  <= pt_q ^ s_q;
          ct_valid_q <= 1'b1;
          ct_index_q <= cnt_q;
          cnt_q      <= cnt_q + 8'd1;
          state_q    <= (cnt_q == 8'(MSG_LEN - 1)) ? DONE : PT_WAIT;
        end
        PT_WAIT: begin
          if (pt_valid) begin
            i_q     <= i_inc_d;
            addr_q  <= i_inc_d;
            phase_q <= PH_PRGA;
            state_q <= RD_I;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Swap operands and the held plaintext byte need no reset.
  always_ff @(posedge clk) begin
    if (state_q == CAP_I) si_q <= s_q;
    if (state_q == WR_I) sj_q <= s_q;
    if (state_q == PT_WAIT && pt_valid) pt_q <= pt_data;
  end

  assign s_address = addr_q;
  assign s_data    = pass_q ? s_q : wdata_q;
  assign s_wren    = wren_q;
  assign ct_data   = ct_data_q;
  assign ct_valid  = ct_valid_q;
  assign ct_index  = ct_index_q;
  assign pt_ready  = (state_q == PT_WAIT);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);

endmodule

// File: doc/rc4_encryptor.md
Name: rc4_encryptor

Overview:
- Encrypting end of the RC4 link: takes a 24-bit secret key and a plaintext byte stream, and produces the ciphertext stream that the decryptor path later consumes from its encrypted-message memory.
- Runs the full RC4 sequence against an external 256x8 single-port S RAM: S initialisation, KSA, then one PRGA step per accepted plaintext byte.
- Sits beside the message source. Its ciphertext output and byte index drive the write port of the encrypted-message memory.

Parameters:
- MSG_LEN, 32, number of plaintext bytes per message (1..256).
- KEY_BYTES, 3, key length in bytes; key byte k = secret_key[8*(KEY_BYTES-k)-1 -: 8], so byte 0 is the MSB.
- DROP_N, 256, keystream bytes discarded when RC4_DROP_EN is defined.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a message. Ignored unless the state is IDLE or DONE.
- secret_key  in  24  key; sampled on the start cycle.
- pt_data  in  8  plaintext byte.
- pt_valid  in  1  pt_data is valid.
- pt_ready  out  1  block will accept pt_data this cycle.
- ct_data  out  8  ciphertext byte.
- ct_valid  out  1  one-cycle strobe; ct_data and ct_index are valid.
- ct_index  out  8  message index of ct_data (0..MSG_LEN-1).
- s_address  out  8  S RAM address.
- s_data  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- s_q  in  8  S RAM read data; valid one clock after the address is presented (registered address, unregistered q).
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE until the next start or reset.

Behaviour:
- Reset (reset_n low at a clock edge), from any state including mid-message:
  - state goes to IDLE; i, j, byte count and latched key clear to 0.
  - all outputs go to 0, including s_wren.
  - S contents are then undefined; the next start fully re-initialises them.
- Only one S access happens per cycle. Reads: drive s_address in cycle n, sample s_q in cycle n+1.
- All index arithmetic is 8-bit and wraps modulo 256.
- IDLE: on start, latch secret_key, set k=0, go to INIT.
- INIT: write S[k]=k with s_wren=1, one write per cycle for k=0..255 (256 cycles); then go to KSA.
- KSA, with i=0..255 and j starting at 0. Each i takes 5 cycles:
  - read S[i];
  - capture si; j = j + si + key[i mod KEY_BYTES];
  - read S[j];
  - capture sj, then write S[i]=sj;
  - write S[j]=si.
- Boundary: when i==j the two writes hit the same address and the second wins; this is correct RC4. After i=255, clear i and j, then go to DROP (feature enabled) or PT_WAIT.
- PT_WAIT: pt_ready=1. A byte is accepted when pt_valid && pt_ready in the same cycle; pt_ready drops the following cycle.
- PRGA step, run per accepted byte:
  - i=i+1; read S[i]; j=j+si; read S[j];
  - write S[i]=sj; write S[j]=si;
  - read S[si+sj] to get keystream byte f.
  - Next cycle: ct_data = pt_byte XOR f, ct_valid=1, ct_index = byte count.
  - Latency from accept to ct_valid is 8 cycles fixed; the bench checks this exactly.
- After each output the byte count increments. When the count reaches MSG_LEN go to DONE (done=1, busy=0); otherwise return to PT_WAIT.
- start asserted while busy: ignored.
- start in DONE: the full sequence restarts, including INIT.
- pt_valid outside PT_WAIT: ignored. The source must hold pt_data until it is accepted.
- ct_valid has no backpressure; the consumer must take the byte in the strobe cycle.

Optional Feature:
- Macro RC4_DROP_EN.
- Defined: after KSA, a DROP state runs DROP_N PRGA steps. Each step does the same swaps but issues no final keystream read and produces no ct_valid. PT_WAIT is entered only after the drop. This is the RC4-dropN variant; the matching decryptor must use the same setting.
- Undefined: DROP state absent; KSA goes directly to PT_WAIT; standard RC4 output.

Test Plan:
- Init: start with key 0x000000 → 256 consecutive cycles of s_wren=1 with s_address=k and s_data=k for k=0..255, then the KSA access pattern begins; busy=1 throughout.
- Known answer, MSG_LEN=9, macro undefined: key 0x4B6579 ("Key"), plaintext 50 6C 61 69 6E 74 65 78 74 ("Plaintext") → ct_data BB F3 16 E8 D9 40 AF 0A D3 at ct_index 0..8, then done=1.
- Round trip: encrypt 32 random bytes with key 0x000249, then run the bytes through a golden RC4 model with the same key → original plaintext recovered; accept-to-ct_valid latency is 8 cycles for every byte.
- Handshake: pt_valid held low for 20 cycles in PT_WAIT → pt_ready stays 1 and no ct_valid appears. start pulsed mid-KSA → ignored and the ciphertext is unchanged.
- Reset mid-PRGA (after byte 4): all outputs are 0 next cycle; a new start with the same key produces the same ct from index 0 as a clean run.
- RC4_DROP_EN, DROP_N=256: output equals golden RC4 keystream bytes 256.. XOR plaintext; no ct_valid occurs during the drop.
